// File: rtl/kontrol_pkg.sv
// rtl/kontrol_pkg.sv - opcodes, FSM states and instruction field positions for kontrol_birimi
package kontrol_pkg;

  localparam int SRC1_LSB = 3;
  localparam int SRC2_LSB = 6;
  localparam int DEST_LSB = 9;
  localparam int OP_LSB   = 12;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    BOSTA,
    AL,
    OKU,
    YURUT,
    YAZ,
    DUR
  } durum_t;

endpackage

// File: rtl/kontrol_alu.sv
// rtl/kontrol_alu.sv - combinational ALU and opcode decode for kontrol_birimi
module kontrol_alu
  import kontrol_pkg::*;
#(
  parameter int VERI_W = 8
) (
  input  logic [3:0]        opcode,
  input  logic [VERI_W-1:0] v1,
  input  logic [VERI_W-1:0] v2,
  input  logic [VERI_W-1:0] imm,
  output logic [VERI_W-1:0] sonuc,
  output logic              tasma,
  output logic              tasma_gunc,
  output logic              yazar,
  output logic              gecersiz
);

  logic [VERI_W:0] gecici;

  // The extra top bit carries out of ADD and is the borrow of SUB.
  always_comb begin
    gecici     = '0;
    yazar      = 1'b1;
    gecersiz   = 1'b0;
    tasma_gunc = 1'b0;
    case (opcode)
      OP_NOP:  yazar = 1'b0;
      OP_ADD: begin
        gecici     = {1'b0, v1} + {1'b0, v2};
        tasma_gunc = 1'b1;
      end
      OP_SUB: begin
        gecici     = {1'b0, v1} - {1'b0, v2};
        tasma_gunc = 1'b1;
      end
      OP_AND:  gecici = {1'b0, v1 & v2};
      OP_OR:   gecici = {1'b0, v1 | v2};
      OP_XOR:  gecici = {1'b0, v1 ^ v2};
      OP_LDI:  gecici = {1'b0, imm};
      OP_MOV:  gecici = {1'b0, v1};
      OP_HALT: yazar = 1'b0;
      default: begin
        yazar    = 1'b0;
        gecersiz = 1'b1;
      end
    endcase
    sonuc = gecici[VERI_W-1:0];
    tasma = gecici[VERI_W];
  end

endmodule

// File: rtl/kontrol_birimi.sv
// rtl/kontrol_birimi.sv - issue/writeback controller driving the hafiza register file
module kontrol_birimi
  import kontrol_pkg::*;
#(
  parameter int VERI_W  = 8,
  parameter int EMIR_W  = 16,
  parameter int SAYAC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               baslat,
  input  logic               emir_gecerli,
  input  logic [EMIR_W-1:0]  emir_i,
  output logic               emir_hazir,
  output logic [EMIR_W-1:0]  emir_o,
  input  logic [VERI_W-1:0]  veri1_i,
  input  logic [VERI_W-1:0]  veri2_i,
  output logic [VERI_W-1:0]  yazilacak_veri_o,
  output logic               veriyi_yaz_o,
  output logic               tasma_o,
  output logic               hata_o,
  output logic               dur_o,
  output logic [SAYAC_W-1:0] komut_sayaci_o
);

  durum_t            durum;
  logic [VERI_W-1:0] v1_r;
  logic [VERI_W-1:0] v2_r;
  logic [VERI_W-1:0] sonuc_r;

  logic [VERI_W-1:0] alu_sonuc;
  logic              alu_tasma;
  logic              alu_tasma_gunc;
  logic              alu_yazar;
  logic              alu_gecersiz;

  kontrol_alu #(.VERI_W(VERI_W)) u_alu (
    .opcode     (emir_o[OP_LSB +: 4]),
    .v1         (v1_r),
    .v2         (v2_r),
    .imm        (emir_o[VERI_W-1:0]),
    .sonuc      (alu_sonuc),
    .tasma      (alu_tasma),
    .tasma_gunc (alu_tasma_gunc),
    .yazar      (alu_yazar),
    .gecersiz   (alu_gecersiz)
  );

  // The write strobe is registered out of YAZ, so it is high in the cycle after YAZ
  // while emir_o still holds the destination of the instruction being retired.
  always_ff @(posedge clk) begin
    if (!rst) begin
      durum            <= BOSTA;
      emir_o           <= '0;
      emir_hazir       <= 1'b0;
      v1_r             <= '0;
      v2_r             <= '0;
      sonuc_r          <= '0;
      yazilacak_veri_o <= '0;
      veriyi_yaz_o     <= 1'b0;
      tasma_o          <= 1'b0;
      hata_o           <= 1'b0;
      dur_o            <= 1'b0;
      komut_sayaci_o   <= '0;
    end else begin
      veriyi_yaz_o <= 1'b0;
      case (durum)
        BOSTA: begin
          if (baslat) begin
            durum      <= AL;
            emir_hazir <= 1'b1;
          end
        end
        AL: begin
          if (emir_gecerli) begin
            emir_o         <= emir_i;
            komut_sayaci_o <= komut_sayaci_o + 1'b1;
            emir_hazir     <= 1'b0;
            durum          <= OKU;
          end
        end
        OKU: begin
          v1_r  <= veri1_i;
          v2_r  <= veri2_i;
          durum <= YURUT;
        end
        YURUT: begin
          sonuc_r <= alu_sonuc;
          if (alu_tasma_gunc) tasma_o <= alu_tasma;
          if (alu_gecersiz) hata_o <= 1'b1;
          if (emir_o[OP_LSB +: 4] == OP_HALT) begin
            dur_o <= 1'b1;
            durum <= DUR;
          end else if (alu_yazar) begin
            durum <= YAZ;
          end else begin
            emir_hazir <= 1'b1;
            durum      <= AL;
          end
        end
        YAZ: begin
          veriyi_yaz_o     <= 1'b1;
          yazilacak_veri_o <= sonuc_r;
          emir_hazir       <= 1'b1;
          durum            <= AL;
        end
        DUR: begin
          dur_o      <= 1'b1;
          emir_hazir <= 1'b0;
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: doc/kontrol_birimi.md
Name: kontrol_birimi

Overview:
Multi-cycle issue/writeback controller that drives the 8x8 register file (hafiza) from the initiator side. It accepts 16-bit instructions over a valid/ready handshake and presents them on emir_o so the register file resolves its two read ports. It captures veri1/veri2, computes an 8-bit ALU result and pulses the register-file write enable with the result. It sits between instruction memory and hafiza.

Parameters:
VERI_W, 8, datapath / register width
EMIR_W, 16, instruction width
SAYAC_W, 8, accepted-instruction counter width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-low reset
baslat  in  1  start pulse; leaves BOSTA
emir_gecerli  in  1  instruction valid from instruction memory
emir_i  in  16  instruction word
emir_hazir  out  1  controller ready to accept an instruction
emir_o  out  16  latched instruction to register file (src1=[5:3], src2=[8:6], dest=[11:9])
veri1_i  in  8  register file read port 1 (addressed by emir_o[5:3])
veri2_i  in  8  register file read port 2 (addressed by emir_o[8:6])
yazilacak_veri_o  out  8  write data to register file
veriyi_yaz_o  out  1  register file write enable, one-cycle pulse
tasma_o  out  1  carry/borrow of last ADD/SUB
hata_o  out  1  sticky illegal-opcode flag
dur_o  out  1  high in DUR (halted)
komut_sayaci_o  out  8  count of accepted instructions

Behaviour:
- Opcodes in emir[15:12]: 0 NOP; 1 ADD (v1+v2); 2 SUB (v1-v2); 3 AND; 4 OR; 5 XOR; 6 LDI (dest <= emir[7:0]); 7 MOV (dest <= v1); F HALT; all others illegal.
- FSM states: BOSTA, AL, OKU, YURUT, YAZ, DUR.
- BOSTA: wait; baslat=1 -> AL.
- AL: emir_hazir=1. emir_gecerli=1 latches emir_i into emir_o and increments komut_sayaci_o. Next state is OKU. Otherwise stay in AL.
- OKU: emir_o stable; register veri1_i/veri2_i at end of cycle.
- YURUT: compute result into 9-bit temp; result = temp[7:0].
  - ADD: tasma = temp[8].
  - SUB: tasma = 1 when v1 < v2 (borrow), result wraps mod 256.
  - Other ops leave tasma unchanged.
  - NOP -> AL. Illegal -> set hata_o, no write, -> AL. HALT -> DUR.
  - Writing ops (1-7) -> YAZ.
- YAZ: veriyi_yaz_o=1 and yazilacak_veri_o=result for exactly one cycle. emir_o unchanged, so dest [11:9] is valid at the write edge. Next state AL.
- DUR: dur_o=1, emir_hazir=0. Exit only via rst.
- Latency: handshake accepted at edge N; veriyi_yaz_o is high during cycle N+3 and the register file writes at edge N+4. Throughput is one writing instruction per 4 cycles.
- emir_hazir is a registered function of state only; no combinational path from emir_gecerli.
- emir_o changes only on an accepted handshake.
- komut_sayaci_o wraps 255 -> 0, counts NOP/illegal/HALT too.
- hata_o is sticky until reset.
- Reset (rst=0 at a posedge), including mid-instruction:
  - state BOSTA; emir_o=16'h0000; yazilacak_veri_o=0; veriyi_yaz_o=0; emir_hazir=0; tasma_o=0; hata_o=0; dur_o=0; komut_sayaci_o=0.
  - A write pending in YAZ is dropped.
- baslat outside BOSTA is ignored.
- emir_gecerli outside AL is ignored; the source must hold the word until emir_hazir.

Decomposition:
- Package kontrol_pkg: opcode localparams (OP_NOP..OP_HALT), state enum, field-slice constants (SRC1_LSB=3, SRC2_LSB=6, DEST_LSB=9, OP_LSB=12).
- One natural sub-module: kontrol_alu (combinational: opcode, v1, v2, imm -> result[7:0], tasma, yazar, gecersiz).
- FSM and counters stay in kontrol_birimi.

Test Plan:
- Bench instantiates kontrol_birimi plus hafiza, preloaded r0..r7 = 12,7,4,43,1,4,26,40.
- Reset, baslat, emir_i=16'h1440 (ADD r2=r0+r1) -> veriyi_yaz_o high exactly 3 cycles after accept, yazilacak_veri_o=19, r2=19, tasma_o=0, komut_sayaci_o=1.
- emir_i=16'h28C8 (SUB r4=r1-r3) -> r4=220, tasma_o=1.
- emir_i=16'h6EA5 (LDI r7=0xA5) then 16'h7238 (MOV r1=r7) -> r7=0xA5, r1=0xA5, two write pulses, emir_hazir low between accepts.
- emir_i=16'h9000 (illegal) -> no write pulse, hata_o=1 sticky; a following 16'h0000 NOP -> no write, counter +2.
- emir_i=16'hF000 -> dur_o=1, emir_hazir stays 0 with emir_gecerli held high. Then rst=0 asserted during YAZ of a prior ADD -> no register write, all outputs at reset values next cycle.
- Stream 256 NOPs -> komut_sayaci_o wraps to 0.
